// File: rtl/letc_pkg.sv
// ----------------------------------------------------------------------------
// letc_pkg
// Shared types for the LETC core writeback stage and its store buffer.
//   mem_size_t : access size encoding (B/H/W/D)
//   rd_src_t   : destination-register source select
//   size_bytes : byte count of an access; D on a 32-bit core collapses to W
// ----------------------------------------------------------------------------
package letc_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2,
    MEM_SIZE_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    RD_SRC_ALU     = 2'd0,
    RD_SRC_MEM     = 2'd1,
    RD_SRC_CSR     = 2'd2,
    RD_SRC_INVALID = 2'd3
  } rd_src_t;

  // Value driven onto rd when the source select is invalid; easy to spot in a trace.
  localparam logic [31:0] RD_POISON = 32'hDEADBEEF;

  function automatic logic [3:0] size_bytes(input mem_size_t size, input logic is_xlen64);
    case (size)
      MEM_SIZE_B: size_bytes = 4'd1;
      MEM_SIZE_H: size_bytes = 4'd2;
      MEM_SIZE_W: size_bytes = 4'd4;
      MEM_SIZE_D: size_bytes = is_xlen64 ? 4'd8 : 4'd4;
      default:    size_bytes = 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/letc_core_store_buffer.sv
// ----------------------------------------------------------------------------
// letc_core_store_buffer
// FIFO of committed stores ({aligned address, merged word}) drained to DMSS,
// with a combinational address snoop over all occupied entries.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   push_i, push_addr_i/data_i enqueue request (ignored when full and not popping)
//   out_valid_o/out_ready_i    drain handshake; head stays stable until popped
//   out_addr_o/out_data_o      head entry
//   pop_o                      drain handshake completes this cycle
//   snoop_addr_i/snoop_hit_o   any occupied entry with the same aligned address
//   full_o, empty_o            occupancy flags
// ----------------------------------------------------------------------------
module letc_core_store_buffer
  import letc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_addr_i,
  input  logic [XLEN-1:0] push_data_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_addr_o,
  output logic [XLEN-1:0] out_data_o,
  output logic            pop_o,
  input  logic [XLEN-1:0] snoop_addr_i,
  output logic            snoop_hit_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int IDX_W  = $clog2(SB_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int LANE_W = $clog2(XLEN / 8);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } sb_entry_t;

  sb_entry_t           entries_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                push_ok_s;
  logic [XLEN-1:0]     snoop_line_s;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign pop_o     = !empty_o && out_ready_i;
  // A pop frees the head slot in the same cycle, so a full buffer may still accept.
  assign push_ok_s = push_i && (!full_o || pop_o);

  assign out_valid_o = !empty_o;
  assign out_addr_o  = entries_q[rd_ptr_q[IDX_W-1:0]].addr;
  assign out_data_o  = entries_q[rd_ptr_q[IDX_W-1:0]].data;

  // Next pointers and per-slot occupancy; a push into the slot being popped keeps it occupied.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    if (pop_o) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q[IDX_W-1:0]] = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q[IDX_W-1:0]] = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Pointer and occupancy state; reset discards every buffered entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload storage, qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      entries_q[wr_ptr_q[IDX_W-1:0]] <= '{addr: push_addr_i, data: push_data_i};
    end
  end

  assign snoop_line_s = {snoop_addr_i[XLEN-1:LANE_W], {LANE_W{1'b0}}};

  // Snoop compare over occupied slots, including a head that is popping this cycle.
  always_comb begin
    snoop_hit_o = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (valid_q[i] && (entries_q[i].addr == snoop_line_s)) begin
        snoop_hit_o = 1'b1;
      end else begin
        snoop_hit_o = snoop_hit_o;
      end
    end
  end

endmodule

// File: rtl/letc_core_stage_writeback_sb.sv
// ----------------------------------------------------------------------------
// letc_core_stage_writeback_sb
// Writeback stage: retires M2 instructions (rd mux, RF write, CSR write) and
// commits stores, merged into the loaded word, to a decoupled store buffer.
// The stage holds (w_ready=0) only when a store retires into a full buffer.
// Optional feature macro: LETC_CORE_WB_RETIRE_CNT_EN enables the 64-bit
// retired-instruction counter; otherwise retire_count is tied to zero.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   w_stall, w_flush, w_ready     pipeline control
//   in_*                          M2->W instruction fields
//   rf_rd_*                       register-file write port
//   csr_idx/csr_we/csr_wdata      CSR write port
//   fwd_*                         bypass to earlier stages
//   sb_out_*                      store drain handshake to DMSS
//   snoop_addr/snoop_hit          load address hazard check
//   sb_empty                      buffer empty (fence/AMO gate)
//   retire_count                  retired-instruction counter
// ----------------------------------------------------------------------------
module letc_core_stage_writeback_sb
  import letc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4,
  parameter int RIDX_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_stall,
  input  logic              w_flush,
  output logic              w_ready,
  input  logic              in_valid,
  input  logic              in_rd_we,
  input  logic [RIDX_W-1:0] in_rd_idx,
  input  logic [1:0]        in_rd_src,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_mem_rdata,
  input  logic [XLEN-1:0]   in_csr_old_val,
  input  logic [XLEN-1:0]   in_csr_new_val,
  input  logic [11:0]       in_csr_idx,
  input  logic              in_csr_we,
  input  logic              in_is_store,
  input  logic [1:0]        in_mem_size,
  input  logic [XLEN-1:0]   in_rs2_val,
  output logic [RIDX_W-1:0] rf_rd_idx,
  output logic [XLEN-1:0]   rf_rd_val,
  output logic              rf_rd_we,
  output logic [11:0]       csr_idx,
  output logic              csr_we,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              fwd_valid,
  output logic [RIDX_W-1:0] fwd_rd_idx,
  output logic [XLEN-1:0]   fwd_rd_val,
  output logic              sb_out_valid,
  input  logic              sb_out_ready,
  output logic [XLEN-1:0]   sb_out_addr,
  output logic [XLEN-1:0]   sb_out_data,
  input  logic [XLEN-1:0]   snoop_addr,
  output logic              snoop_hit,
  output logic              sb_empty,
  output logic [63:0]       retire_count
);

  localparam int LANE_W = $clog2(XLEN / 8);

  logic              ff_valid_q;
  logic              ff_rd_we_q, ff_csr_we_q, ff_is_store_q;
  logic [RIDX_W-1:0] ff_rd_idx_q;
  rd_src_t           ff_rd_src_q;
  mem_size_t         ff_size_q;
  logic [XLEN-1:0]   ff_alu_q, ff_mem_q, ff_csr_old_q, ff_csr_new_q, ff_rs2_q;
  logic [11:0]       ff_csr_idx_q;

  logic              sb_full_s, sb_pop_s, blocked_s, retire_s, load_s;
  logic [XLEN-1:0]   rd_val_s, mask_s, merged_s;
  logic [3:0]        bytes_s;
  logic [LANE_W-1:0] off_s;

  assign blocked_s = ff_valid_q && ff_is_store_q && sb_full_s && !sb_pop_s;
  assign w_ready   = !blocked_s;
  assign retire_s  = ff_valid_q && !w_flush && !w_stall && !blocked_s;
  // A blocked store keeps its slot until it retires; a flush releases the slot.
  assign load_s    = !w_stall && (w_ready || w_flush);

  // Stage occupancy; a flush while stalled still kills the resident instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_valid_q <= 1'b0;
    end else if (load_s) begin
      ff_valid_q <= in_valid;
    end else if (w_flush) begin
      ff_valid_q <= 1'b0;
    end else begin
      ff_valid_q <= ff_valid_q;
    end
  end

  // Instruction payload registers, qualified by ff_valid_q so they need no reset.
  always_ff @(posedge clk) begin
    if (load_s) begin
      ff_rd_we_q    <= in_rd_we;
      ff_rd_idx_q   <= in_rd_idx;
      ff_rd_src_q   <= rd_src_t'(in_rd_src);
      ff_alu_q      <= in_alu_result;
      ff_mem_q      <= in_mem_rdata;
      ff_csr_old_q  <= in_csr_old_val;
      ff_csr_new_q  <= in_csr_new_val;
      ff_csr_idx_q  <= in_csr_idx;
      ff_csr_we_q   <= in_csr_we;
      ff_is_store_q <= in_is_store;
      ff_size_q     <= mem_size_t'(in_mem_size);
      ff_rs2_q      <= in_rs2_val;
    end
  end

  // Destination register source select.
  always_comb begin
    case (ff_rd_src_q)
      RD_SRC_ALU: rd_val_s = ff_alu_q;
      RD_SRC_MEM: rd_val_s = ff_mem_q;
      RD_SRC_CSR: rd_val_s = ff_csr_old_q;
      default:    rd_val_s = XLEN'(RD_POISON);
    endcase
  end

  // Store merge: rs2 low bytes overwrite the loaded word at the size-aligned lane offset.
  always_comb begin
    bytes_s = size_bytes(ff_size_q, XLEN == 64);
    off_s   = ff_alu_q[LANE_W-1:0] & ~LANE_W'(bytes_s - 4'd1);
    case (bytes_s)
      4'd1:    mask_s = XLEN'(8'hFF);
      4'd2:    mask_s = XLEN'(16'hFFFF);
      4'd8:    mask_s = {XLEN{1'b1}};
      default: mask_s = XLEN'(32'hFFFF_FFFF);
    endcase
    merged_s = (ff_mem_q & ~(mask_s << {off_s, 3'b000})) |
               ((ff_rs2_q & mask_s) << {off_s, 3'b000});
  end

  assign rf_rd_idx  = ff_rd_idx_q;
  assign rf_rd_val  = rd_val_s;
  assign rf_rd_we   = retire_s && ff_rd_we_q;
  assign csr_idx    = ff_csr_idx_q;
  assign csr_wdata  = ff_csr_new_q;
  assign csr_we     = retire_s && ff_csr_we_q;
  assign fwd_valid  = ff_valid_q && ff_rd_we_q;
  assign fwd_rd_idx = ff_rd_idx_q;
  assign fwd_rd_val = rd_val_s;

  letc_core_store_buffer #(
    .XLEN     (XLEN),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (retire_s && ff_is_store_q),
    .push_addr_i  ({ff_alu_q[XLEN-1:LANE_W], {LANE_W{1'b0}}}),
    .push_data_i  (merged_s),
    .out_ready_i  (sb_out_ready),
    .out_valid_o  (sb_out_valid),
    .out_addr_o   (sb_out_addr),
    .out_data_o   (sb_out_data),
    .pop_o        (sb_pop_s),
    .snoop_addr_i (snoop_addr),
    .snoop_hit_o  (snoop_hit),
    .full_o       (sb_full_s),
    .empty_o      (sb_empty)
  );

`ifdef LETC_CORE_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Retired-instruction counter, wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_q <= 64'd0;
    end else if (retire_s) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end else begin
      retire_cnt_q <= retire_cnt_q;
    end
  end

  assign retire_count = retire_cnt_q;
`else
  assign retire_count = 64'd0;
`endif

endmodule
